ws2812_bit_decoder: RTL and testbench

// - Front end of the WS2812 receive path. Oversamples the raw serial data pin and measures

---
 rtl/ws2812_bit_decoder.sv | 187 ++++++++++++++++++
 tb/tb_ws2812_bit_decoder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_bit_decoder.sv
`default_nettype none
// ============================================================================
// Module  : ws2812_bit_decoder
// Brief   : WS2812 pulse-width bit recovery with frame-reset and error strobes.
//           Optional o_bit_count statistics via WS2812_DECODER_STATS_EN.
// Revision: 1.0 - initial release
// ============================================================================
module ws2812_bit_decoder #(
  parameter int SYNC_STAGES   = 2,
  parameter int MIN_PULSE_CYC = 5,
  parameter int T_THRESH_CYC  = 30,
  parameter int T_MAXHIGH_CYC = 500,
  parameter int T_RESET_CYC   = 2500
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_din,
  output logic        o_shift_en,
  output logic        o_decode_bit,
  output logic        o_treset,
  output logic        o_err
`ifdef WS2812_DECODER_STATS_EN
  ,
  output logic [15:0] o_bit_count
`endif
);

  localparam int CNT_W     = $clog2(T_RESET_CYC + 1);
  localparam int PRIME_MAX = SYNC_STAGES + 1;
  localparam int PRIME_W   = $clog2(PRIME_MAX + 1);

  localparam logic [CNT_W-1:0]   C_RESET_MAX  = CNT_W'(T_RESET_CYC);
  localparam logic [CNT_W-1:0]   C_RESET_M1   = CNT_W'(T_RESET_CYC - 1);
  localparam logic [CNT_W-1:0]   C_MAXHIGH_M1 = CNT_W'(T_MAXHIGH_CYC - 1);
  localparam logic [CNT_W-1:0]   C_MIN_PULSE  = CNT_W'(MIN_PULSE_CYC);
  localparam logic [CNT_W-1:0]   C_THRESH     = CNT_W'(T_THRESH_CYC);
  localparam logic [PRIME_W-1:0] C_PRIMED     = PRIME_W'(PRIME_MAX);

  typedef enum logic [1:0] {
    ST_LOW   = 2'd0,
    ST_HIGH  = 2'd1,
    ST_STUCK = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s_dly_q, s_dly_d;
  logic [PRIME_W-1:0]     prime_q, prime_d;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       low_cnt_q, low_cnt_d;
  logic [CNT_W-1:0]       high_cnt_q, high_cnt_d;
  logic                   shift_evt_q, shift_evt_d;
  logic                   bit_evt_q, bit_evt_d;
  logic                   treset_evt_q, treset_evt_d;
  logic                   err_evt_q, err_evt_d;
  logic                   shift_en_q, shift_en_d;
  logic                   decode_bit_q, decode_bit_d;
  logic                   treset_q, treset_d;
  logic                   err_q, err_d;
  logic                   s, primed, rise, fall;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], i_din};
    s       = sync_q[SYNC_STAGES-1];
    s_dly_d = s;
    // Edges are ignored until the synchronizer and s_dly hold real samples, so a
    // line already high when reset drops cannot fake a rise and half-decode a bit.
    primed  = (prime_q == C_PRIMED);
    prime_d = primed ? prime_q : prime_q + PRIME_W'(1);
    rise    = primed & s & ~s_dly_q;
    fall    = primed & ~s & s_dly_q;

    state_d      = state_q;
    low_cnt_d    = low_cnt_q;
    high_cnt_d   = high_cnt_q;
    shift_evt_d  = 1'b0;
    bit_evt_d    = 1'b0;
    treset_evt_d = 1'b0;
    err_evt_d    = 1'b0;

    case (state_q)
      ST_LOW: begin
        if (low_cnt_q != C_RESET_MAX) begin
          low_cnt_d    = low_cnt_q + CNT_W'(1);
          treset_evt_d = (low_cnt_q == C_RESET_M1);
        end
        if (rise) begin
          state_d    = ST_HIGH;
          high_cnt_d = CNT_W'(1);
          low_cnt_d  = '0;
        end
      end
      ST_HIGH: begin
        if (fall) begin
          state_d = ST_LOW;
          if (high_cnt_q < C_MIN_PULSE) begin
            err_evt_d = 1'b1;
          end else begin
            shift_evt_d = 1'b1;
            bit_evt_d   = (high_cnt_q >= C_THRESH);
          end
        end else begin
          high_cnt_d = high_cnt_q + CNT_W'(1);
          if (high_cnt_q == C_MAXHIGH_M1) begin
            err_evt_d = 1'b1;
            state_d   = ST_STUCK;
          end
        end
      end
      ST_STUCK: begin
        if (fall) begin
          state_d   = ST_LOW;
          low_cnt_d = '0;
        end
      end
      default: state_d = ST_LOW;
    endcase

    shift_en_d   = shift_evt_q;
    decode_bit_d = shift_evt_q ? bit_evt_q : decode_bit_q;
    treset_d     = treset_evt_q;
    err_d        = err_evt_q;
  end

`ifdef WS2812_DECODER_STATS_EN
  logic [15:0] bit_count_q, bit_count_d;

  always_comb begin
    bit_count_d = bit_count_q;
    if (treset_q) begin
      bit_count_d = '0;
    end else if (shift_en_q && (bit_count_q != 16'hFFFF)) begin
      bit_count_d = bit_count_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      bit_count_q <= '0;
    end else begin
      bit_count_q <= bit_count_d;
    end
  end

  assign o_bit_count = bit_count_q;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync_q       <= '0;
      s_dly_q      <= 1'b0;
      prime_q      <= '0;
      state_q      <= ST_LOW;
      low_cnt_q    <= '0;
      high_cnt_q   <= '0;
      shift_evt_q  <= 1'b0;
      bit_evt_q    <= 1'b0;
      treset_evt_q <= 1'b0;
      err_evt_q    <= 1'b0;
      shift_en_q   <= 1'b0;
      decode_bit_q <= 1'b0;
      treset_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      s_dly_q      <= s_dly_d;
      prime_q      <= prime_d;
      state_q      <= state_d;
      low_cnt_q    <= low_cnt_d;
      high_cnt_q   <= high_cnt_d;
      shift_evt_q  <= shift_evt_d;
      bit_evt_q    <= bit_evt_d;
      treset_evt_q <= treset_evt_d;
      err_evt_q    <= err_evt_d;
      shift_en_q   <= shift_en_d;
      decode_bit_q <= decode_bit_d;
      treset_q     <= treset_d;
      err_q        <= err_d;
    end
  end

  assign o_shift_en   = shift_en_q;
  assign o_decode_bit = decode_bit_q;
  assign o_treset     = treset_q;
  assign o_err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ws2812_bit_decoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_ws2812_bit_decoder
// Brief   : Self-checking bench; pulse-level event model versus observed strobes.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ws2812_bit_decoder;

  localparam int SYNC    = 2;
  localparam int T_RESET = 2500;
  localparam int EV_ZERO = 0;
  localparam int EV_ONE  = 1;
  localparam int EV_TRES = 2;
  localparam int EV_ERR  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;
  logic shift_en, decode_bit, treset, err;
`ifdef WS2812_DECODER_STATS_EN
  logic [15:0] bit_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  int obs_q[$];

  ws2812_bit_decoder dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_din        (din),
    .o_shift_en   (shift_en),
    .o_decode_bit (decode_bit),
    .o_treset     (treset),
    .o_err        (err)
`ifdef WS2812_DECODER_STATS_EN
    ,
    .o_bit_count  (bit_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pulse-level reference: classify the high width, then the low width.
  task automatic model_pulse(input int hi, input int lo);
    if (hi < 5 || hi >= 500) exp_q.push_back(EV_ERR);
    else exp_q.push_back((hi >= 30) ? EV_ONE : EV_ZERO);
    if (lo >= T_RESET) exp_q.push_back(EV_TRES);
  endtask

  // Called #1 after a posedge; returns #1 after a posedge.
  task automatic send(input int hi, input int lo);
    din = 1'b1;
    repeat (hi) @(posedge clk);
    #1 din = 1'b0;
    repeat (lo) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int hi, input int lo);
    send(hi, lo);
    model_pulse(hi, lo);
  endtask

  task automatic compare_events(input string tag);
    check_eq({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check_eq(tag, obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  always @(negedge clk) begin
    if (shift_en === 1'b1) obs_q.push_back(decode_bit ? EV_ONE : EV_ZERO);
    if (treset === 1'b1) obs_q.push_back(EV_TRES);
    if (err === 1'b1) obs_q.push_back(EV_ERR);
    if ((shift_en === 1'b1) || (treset === 1'b1))
      check_eq("shift_treset_exclusive", int'(shift_en & treset), 0);
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bit found;
    int hi, lo;

    repeat (5) @(posedge clk);
    @(negedge clk);
    check_eq("rst_shift_en", shift_en, 0);
    check_eq("rst_decode_bit", decode_bit, 0);
    check_eq("rst_treset", treset, 0);
    check_eq("rst_err", err, 0);
`ifdef WS2812_DECODER_STATS_EN
    check_eq("rst_bit_count", bit_count, 0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    obs_q.delete();

    // 24 ones then a long low; treset position measured from first low sample
    for (int i = 0; i < 23; i++) pulse(40, 40);
    din = 1'b1;
    repeat (40) @(posedge clk);
    #1 din = 1'b0;
    k = 0;
    found = 1'b0;
    while (k < 2600 && !found) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      found = treset;
    end
    check_eq("lat_treset", found ? k : 0, T_RESET + SYNC + 2);
`ifdef WS2812_DECODER_STATS_EN
    check_eq("bit_count_at_treset", bit_count, 24);
    @(posedge clk);
    k++;
    @(negedge clk);
    check_eq("bit_count_after_treset", bit_count, 0);
`endif
    repeat (3000 - k) @(posedge clk);
    #1;
    model_pulse(40, 3000);
    compare_events("frame24");

    // Single zero bit with strobe latency measurement
    din = 1'b1;
    repeat (20) @(posedge clk);
    #1 din = 1'b0;
    k = 0;
    found = 1'b0;
    while (k < 20 && !found) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      found = shift_en;
    end
    check_eq("lat_shift", found ? k : 0, SYNC + 2);
    repeat (60 - k) @(posedge clk);
    #1;
    model_pulse(20, 60);
    compare_events("zero_bit");

    for (int i = 0; i < 24; i++) pulse(40, 40);
    compare_events("ones24");

    pulse(3, 30);
    pulse(40, 40);
    pulse(4, 20);
    pulse(5, 20);
    pulse(29, 20);
    pulse(30, 20);
    compare_events("glitch_thresh");

    pulse(1000, 2600);
    pulse(500, 30);
    pulse(499, 30);
    pulse(40, 2499);
    pulse(40, 2500);
    pulse(10, 40);
    compare_events("stuck_lowtime");

    // Reset in the middle of a 40-cycle pulse discards it
    din = 1'b1;
    repeat (25) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("postrst_shift_en", shift_en, 0);
    check_eq("postrst_decode_bit", decode_bit, 0);
    check_eq("postrst_treset", treset, 0);
    check_eq("postrst_err", err, 0);
    repeat (14) @(posedge clk);
    #1 din = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    obs_q = obs_q;
    compare_events("midpulse_reset");
    pulse(40, 40);
    compare_events("after_reset");

    for (int i = 0; i < 60; i++) begin
      hi = ($urandom_range(0, 15) == 0) ? int'($urandom_range(495, 505)) : int'($urandom_range(1, 60));
      lo = ($urandom_range(0, 15) == 0) ? int'($urandom_range(2495, 2505)) : int'($urandom_range(1, 80));
      if (i == 59) lo = 3000;
      pulse(hi, lo);
    end
    compare_events("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
